// File: rtl/ldpc_defs.sv
// ---------------------------------------------------------------------------
// ldpc_defs
// Definitions shared by the ldpc_* blocks:
//   LDPC_LLRWIDTH - default LLR width common to the decoder datapath
//   rd_state_t    - read-side sweep FSM encoding
//   lane_lsb()    - bit offset of lane k in a flat multi-lane bus
//                   (lane k lives at [lane_lsb(k, w) +: w])
// ---------------------------------------------------------------------------
package ldpc_defs;

  localparam int LDPC_LLRWIDTH = 4;

  typedef enum logic {
    RD_IDLE  = 1'b0,
    RD_SWEEP = 1'b1
  } rd_state_t;

  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/ldpc_llr_bank.sv
// ---------------------------------------------------------------------------
// ldpc_llr_bank
// NUMINPS x LLRWIDTH register file. One lane is written per cycle when
// wr_en is high; all lanes are visible at once on the flat rd_data bus.
// Ports:
//   clk      - rising-edge clock
//   rst      - asynchronous active-low reset, clears all lanes
//   wr_en    - write strobe
//   wr_lane  - lane index to write
//   wr_data  - LLR to store
//   rd_data  - flat read-out, lane k at [k*LLRWIDTH +: LLRWIDTH]
// ---------------------------------------------------------------------------
module ldpc_llr_bank
  import ldpc_defs::*;
#(
  parameter int LLRWIDTH = LDPC_LLRWIDTH,
  parameter int NUMINPS  = 4,
  parameter int SELBITS  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [SELBITS-1:0]           wr_lane,
  input  logic [LLRWIDTH-1:0]          wr_data,
  output logic [NUMINPS*LLRWIDTH-1:0]  rd_data
);

  genvar k;
  generate
    for (k = 0; k < NUMINPS; k++) begin : g_lane
      logic [LLRWIDTH-1:0] lane_q;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          lane_q <= '0;
        end else if (wr_en && (wr_lane == SELBITS'(k))) begin
          lane_q <= wr_data;
        end
      end

      assign rd_data[lane_lsb(k, LLRWIDTH) +: LLRWIDTH] = lane_q;
    end
  endgenerate

endmodule

// File: rtl/ldpc_llr_gather.sv
// ---------------------------------------------------------------------------
// ldpc_llr_gather
// Double-buffered serial-to-bank feeder for ldpc_muxreg. LLRs arrive one at
// a time under valid/ready and are packed into one of two NUMINPS-lane
// banks. A completed bank is presented on din while sel sweeps lanes
// 0..NUMINPS-1, one per cycle. Filling one bank overlaps sweeping the other.
// Ports:
//   clk        - rising-edge clock
//   rst        - asynchronous active-low reset
//   flush      - synchronous abort of all buffered work (bank data kept)
//   llr_in     - input LLR
//   llr_valid  - llr_in valid
//   llr_ready  - gather can accept (registers only)
//   din        - contents of the bank being swept
//   sel        - lane select to the muxreg
//   sel_valid  - sel meaningful this cycle
//   sel_last   - last lane of the sweep
//   dout_valid - sel_valid delayed one cycle (muxreg output alignment)
//
// Read-side FSM
//   state    | meaning
//   RD_IDLE  | no full bank to sweep, sel held at 0, sel_valid low
//   RD_SWEEP | presenting bank rd_bank, sel walks 0..NUMINPS-1
// ---------------------------------------------------------------------------
module ldpc_llr_gather
  import ldpc_defs::*;
#(
  parameter int LLRWIDTH = LDPC_LLRWIDTH,
  parameter int NUMINPS  = 4,
  parameter int SELBITS  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic [LLRWIDTH-1:0]          llr_in,
  input  logic                         llr_valid,
  output logic                         llr_ready,
  output logic [NUMINPS*LLRWIDTH-1:0]  din,
  output logic [SELBITS-1:0]           sel,
  output logic                         sel_valid,
  output logic                         sel_last,
  output logic                         dout_valid
);

  localparam logic [SELBITS-1:0] LAST_LANE = SELBITS'(NUMINPS - 1);

  logic                        wr_bank;
  logic [SELBITS-1:0]          wr_lane;
  logic                        rd_bank;
  logic [1:0]                  full;
  logic [1:0]                  full_set;
  logic [1:0]                  full_clr;
  logic [1:0]                  avail;
  logic                        xfer;
  logic                        wr_last;
  logic                        sweep_end;
  rd_state_t                   state;
  rd_state_t                   state_nxt;
  logic [SELBITS-1:0]          sel_nxt;
  logic [NUMINPS*LLRWIDTH-1:0] bank0_data;
  logic [NUMINPS*LLRWIDTH-1:0] bank1_data;

  // ------------------------------------------------------------------
  // Write side
  // ------------------------------------------------------------------
  assign llr_ready = !full[wr_bank];
  assign xfer      = llr_valid & llr_ready & !flush;
  assign wr_last   = xfer & (wr_lane == LAST_LANE);

  always_comb begin
    full_set = '0;
    if (wr_last) full_set[wr_bank] = 1'b1;
  end

  // A bank completing this cycle counts as available so the sweep can
  // chain into it without a bubble.
  assign avail = full | full_set;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_bank <= 1'b0;
      wr_lane <= '0;
      full    <= '0;
    end else if (flush) begin
      wr_bank <= 1'b0;
      wr_lane <= '0;
      full    <= '0;
    end else begin
      full <= (full | full_set) & ~full_clr;
      if (xfer) begin
        if (wr_last) begin
          wr_lane <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_lane <= wr_lane + 1'b1;
        end
      end
    end
  end

  ldpc_llr_bank #(
    .LLRWIDTH (LLRWIDTH),
    .NUMINPS  (NUMINPS),
    .SELBITS  (SELBITS)
  ) u_bank0 (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (xfer & (wr_bank == 1'b0)),
    .wr_lane (wr_lane),
    .wr_data (llr_in),
    .rd_data (bank0_data)
  );

  ldpc_llr_bank #(
    .LLRWIDTH (LLRWIDTH),
    .NUMINPS  (NUMINPS),
    .SELBITS  (SELBITS)
  ) u_bank1 (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (xfer & (wr_bank == 1'b1)),
    .wr_lane (wr_lane),
    .wr_data (llr_in),
    .rd_data (bank1_data)
  );

  // ------------------------------------------------------------------
  // Read side FSM: state register
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= RD_IDLE;
      sel        <= '0;
      rd_bank    <= 1'b0;
      dout_valid <= 1'b0;
    end else if (flush) begin
      state      <= RD_IDLE;
      sel        <= '0;
      rd_bank    <= 1'b0;
      dout_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      sel        <= sel_nxt;
      dout_valid <= sel_valid;
      if (sweep_end) rd_bank <= ~rd_bank;
    end
  end

  // ------------------------------------------------------------------
  // Read side FSM: next state
  // ------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    case (state)
      RD_IDLE: begin
        sel_nxt = '0;
        if (avail[rd_bank]) state_nxt = RD_SWEEP;
      end
      RD_SWEEP: begin
        if (sel == LAST_LANE) begin
          sel_nxt = '0;
          if (!avail[~rd_bank]) state_nxt = RD_IDLE;
        end else begin
          sel_nxt = sel + 1'b1;
        end
      end
      default: begin
        state_nxt = RD_IDLE;
        sel_nxt   = '0;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Read side FSM: outputs
  // ------------------------------------------------------------------
  always_comb begin
    sel_valid = (state == RD_SWEEP);
    sel_last  = sel_valid & (sel == LAST_LANE);
    sweep_end = sel_last;
    full_clr  = '0;
    if (sweep_end) full_clr[rd_bank] = 1'b1;
    din = rd_bank ? bank1_data : bank0_data;
  end

endmodule

// File: tb/tb_ldpc_llr_gather.sv
module tb_ldpc_llr_gather;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic [3:0]  llr_in = '0;
  logic        llr_valid = 1'b0;
  logic        llr_ready;
  logic [15:0] din;
  logic [1:0]  sel;
  logic        sel_valid;
  logic        sel_last;
  logic        dout_valid;

  int          n_tests = 0;
  int          n_fail = 0;
  logic [3:0]  exp_q[$];
  int          pop_cnt = 0;
  int          sv_run = 0;
  int          sv_max = 0;
  int          ready_low_cnt = 0;
  logic        prev_sv = 1'b0;
  logic        prev_flush = 1'b0;

  ldpc_llr_gather #(
    .LLRWIDTH (4),
    .NUMINPS  (4),
    .SELBITS  (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .llr_in     (llr_in),
    .llr_valid  (llr_valid),
    .llr_ready  (llr_ready),
    .din        (din),
    .sel        (sel),
    .sel_valid  (sel_valid),
    .sel_last   (sel_last),
    .dout_valid (dout_valid)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor / scoreboard: every swept lane must carry the next accepted LLR.
  always @(negedge clk) begin
    int es;
    logic [3:0] ev;
    if (!rst) begin
      prev_sv    = 1'b0;
      prev_flush = 1'b0;
      sv_run     = 0;
    end else begin
      chk("dout_valid", 32'(dout_valid), 32'(prev_sv & ~prev_flush));
      if (sel_valid) begin
        es = pop_cnt % 4;
        chk("sel", 32'(sel), es);
        chk("sel_last", 32'(sel_last), 32'(es == 3));
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          ev = exp_q.pop_front();
          chk("lane_data", 32'(din[es*4 +: 4]), 32'(ev));
        end
        pop_cnt++;
        sv_run++;
        if (sv_run > sv_max) sv_max = sv_run;
      end else begin
        chk("sel_last_idle", 32'(sel_last), 0);
        sv_run = 0;
      end
      if (llr_valid && !llr_ready) ready_low_cnt++;
      prev_sv    = sel_valid;
      prev_flush = flush;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] v);
    int w;
    w = 0;
    llr_in    = v;
    llr_valid = 1'b1;
    @(negedge clk);
    while (!llr_ready && w < 20) begin
      w++;
      @(negedge clk);
    end
    if (!llr_ready) begin
      chk("ready_timeout", 0, 1);
      llr_valid = 1'b0;
    end else begin
      exp_q.push_back(v);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    flush     = 1'b1;
    llr_valid = 1'b1;
    llr_in    = 4'hE;
    step();
    flush     = 1'b0;
    llr_valid = 1'b0;
    exp_q.delete();
    pop_cnt = 0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((exp_q.size() != 0 || sel_valid) && w < 60) begin
      step();
      w++;
    end
    chk("drain_left", exp_q.size(), 0);
    chk("drain_idle", 32'(sel_valid), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_llr_ready", 32'(llr_ready), 1);
    chk("rst_sel", 32'(sel), 0);
    chk("rst_sel_valid", 32'(sel_valid), 0);
    chk("rst_sel_last", 32'(sel_last), 0);
    chk("rst_dout_valid", 32'(dout_valid), 0);
    chk("rst_din", 32'(din), 0);
    rst = 1'b1;
    step();

    // single bank 1,2,3,4
    for (int i = 1; i <= 4; i++) send(4'(i));
    llr_valid = 1'b0;
    chk("t1_sel_valid", 32'(sel_valid), 1);
    chk("t1_sel0", 32'(sel), 0);
    chk("t1_din", 32'(din), 32'h4321);
    chk("t1_dout_valid_early", 32'(dout_valid), 0);
    repeat (3) step();
    chk("t1_sel3", 32'(sel), 3);
    chk("t1_sel_last", 32'(sel_last), 1);
    step();
    chk("t1_end_sel_valid", 32'(sel_valid), 0);
    chk("t1_end_dout_valid", 32'(dout_valid), 1);
    step();
    chk("t1_dout_valid_off", 32'(dout_valid), 0);
    drain();

    // 12 back-to-back
    sv_max = 0;
    ready_low_cnt = 0;
    for (int i = 0; i < 12; i++) send(4'(i + 3));
    llr_valid = 1'b0;
    drain();
    chk("t2_ready_low", ready_low_cnt, 0);
    chk("t2_sel_valid_run", sv_max, 12);

    // 8 then a short pause then 4
    ready_low_cnt = 0;
    for (int i = 0; i < 8; i++) send(4'(15 - i));
    llr_valid = 1'b0;
    repeat (2) step();
    for (int i = 0; i < 4; i++) send(4'(i * 3));
    llr_valid = 1'b0;
    drain();
    chk("t3_ready_low", ready_low_cnt, 0);

    // flush after 2 LLRs of a bank
    send(4'hA);
    send(4'hB);
    do_flush();
    chk("t4_llr_ready", 32'(llr_ready), 1);
    chk("t4_sel_valid", 32'(sel_valid), 0);
    send(4'h1); send(4'h3); send(4'h5); send(4'h7);
    llr_valid = 1'b0;
    chk("t4_din", 32'(din), 32'h7531);
    drain();

    // flush during sweep at sel=2 with next bank partly filled
    send(4'h5); send(4'h6); send(4'h7); send(4'h8);
    send(4'h9); send(4'hA);
    llr_valid = 1'b0;
    chk("t5_sel_pre", 32'(sel), 2);
    chk("t5_sel_valid_pre", 32'(sel_valid), 1);
    do_flush();
    chk("t5_sel_valid", 32'(sel_valid), 0);
    chk("t5_llr_ready", 32'(llr_ready), 1);
    chk("t5_dout_valid", 32'(dout_valid), 0);
    chk("t5_sel", 32'(sel), 0);
    step();
    chk("t5_dout_valid2", 32'(dout_valid), 0);
    chk("t5_sel_valid2", 32'(sel_valid), 0);
    send(4'h2); send(4'h4); send(4'h6); send(4'h8);
    llr_valid = 1'b0;
    drain();

    // asynchronous reset mid-sweep
    send(4'hC); send(4'hD); send(4'hE); send(4'hF);
    llr_valid = 1'b0;
    step();
    chk("t6_sel_pre", 32'(sel), 1);
    #1;
    rst = 1'b0;
    #1;
    chk("t6_llr_ready", 32'(llr_ready), 1);
    chk("t6_sel", 32'(sel), 0);
    chk("t6_sel_valid", 32'(sel_valid), 0);
    chk("t6_sel_last", 32'(sel_last), 0);
    chk("t6_dout_valid", 32'(dout_valid), 0);
    chk("t6_din", 32'(din), 0);
    exp_q.delete();
    pop_cnt = 0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    step();
    send(4'h9); send(4'h8); send(4'h7); send(4'h6);
    llr_valid = 1'b0;
    chk("t6_din_after", 32'(din), 32'h6789);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
